led_matrix_scanner: RTL

- Parametrised successor to the single-digit seven-segment-to-matrix adapter for the iCEFUN LED matrix.
- Drives NUM_DIGITS digits side by side, each digit 4 columns x 8 rows, using the fixed segment-to-pixel map (below).
- Adds synchronous reset, a blanking gap at every column change (anti-ghosting), PWM brightness, and tear-free frame-latched input.
- Sits between the user design's active-low segment outputs and the board's active-low row/column pins.

---
 rtl/icefun_matrix_pkg.sv | 22 ++
 rtl/matrix_scan_timer.sv | 41 ++++
 rtl/led_matrix_scanner.sv | 65 ++++++
 3 files changed

// File: rtl/icefun_matrix_pkg.sv
// icefun_matrix_pkg: segment indices, matrix geometry and the segment-to-pixel map
package icefun_matrix_pkg;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_DP = 7;
    localparam int ROWS = 8;
    localparam int COLS_PER_DIGIT = 4;

    // Active-high lit rows for local column lc of a digit with active-low segments seg.
    function automatic logic [ROWS-1:0] seg_col_rows(input logic [7:0] seg, input logic [1:0] lc);
        logic [7:0] on;
        on = ~seg;
        return (lc == 2'd0) ? {2'b00, on[SEG_E], on[SEG_E], 1'b0, on[SEG_F], on[SEG_F], 1'b0} :
               (lc == 2'd3) ? {on[SEG_DP], 1'b0, on[SEG_C], on[SEG_C], 1'b0, on[SEG_B], on[SEG_B], 1'b0} :
                              {1'b0, on[SEG_D], 2'b00, on[SEG_G], 2'b00, on[SEG_A]};
    endfunction
endpackage

// File: rtl/matrix_scan_timer.sv
// matrix_scan_timer: dwell phase and column counters, blank/PWM gating and frame pulse
module matrix_scan_timer #(
    parameter int NCOLS = 4,
    parameter int DIV_W = 13,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W = 3,
    localparam int CW = $clog2(NCOLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [CW-1:0]       col_idx,
    output logic                gate_on,
    output logic                frame_start
);
    localparam logic [DIV_W-1:0] BLANK_P = DIV_W'(BLANK_CYCLES);
    localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

    logic [DIV_W-1:0] p_q, p_d;
    logic [CW-1:0] col_q, col_d;

    // Next counter state plus combinational gating derived from the current counters
    always_comb begin
        p_d = p_q + 1'b1;
        col_d = (&p_q) ? ((col_q == LAST_COL) ? '0 : col_q + 1'b1) : col_q;
        gate_on = (p_q >= BLANK_P) && (p_q[DIV_W-1 -: BRIGHT_W] < brightness);
        frame_start = !reset && (p_q == '0) && (col_q == '0);
        col_idx = col_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
            col_q <= '0;
        end else begin
            p_q <= p_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: multi-digit seven-segment to LED matrix scanner with blanking and PWM
module led_matrix_scanner
    import icefun_matrix_pkg::*;
#(
    parameter int NUM_DIGITS = 1,
    parameter int DIV_W = 13,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W = 3,
    localparam int NCOLS = COLS_PER_DIGIT * NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [ROWS-1:0]         row_out,
    output logic [NCOLS-1:0]        col_out,
    output logic                    frame_start
);
    localparam int CW = $clog2(NCOLS);

    logic [CW-1:0] col_idx;
    logic gate_on;
    logic [8*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [ROWS-1:0] row_q, row_d;
    logic [NCOLS-1:0] col_q, col_d;
    logic [7:0] digit_seg;

    matrix_scan_timer #(
        .NCOLS(NCOLS),
        .DIV_W(DIV_W),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BRIGHT_W(BRIGHT_W)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .brightness(brightness),
        .col_idx(col_idx),
        .gate_on(gate_on),
        .frame_start(frame_start)
    );

    // Latch the frame at its start; map the active column's digit byte to row drive
    always_comb begin
        shadow_d = frame_start ? seg_in : shadow_q;
        digit_seg = 8'(shadow_q >> (8 * (col_idx / COLS_PER_DIGIT)));
        row_d = gate_on ? ~seg_col_rows(digit_seg, col_idx[1:0]) : '1;
        col_d = gate_on ? ~(NCOLS'(1) << col_idx) : '1;
    end

    // Shadow frame and registered active-low outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '1;
            row_q <= '1;
            col_q <= '1;
        end else begin
            shadow_q <= shadow_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_out = row_q;
    assign col_out = col_q;
endmodule
